// File: rtl/cru_pkg.sv
// rtl/cru_pkg.sv - shared CRU constants, width helper, parameter check and address decode
package cru_pkg;

  localparam logic [3:0] CRU_SPACE_HI = 4'h1;

  function automatic int cru_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit cru_params_ok(input int num_bits, input int pulse_len);
    return (num_bits >= 1) && (num_bits <= 32) && (pulse_len >= 1);
  endfunction

  // Word address reads as hex digits 0x<hi><base><index>; index bit 7 set is out of range.
  function automatic logic cru_hit(input logic [0:14] addr, input logic [3:0] base,
                                   input logic [3:0] base_hi, input int num_bits);
    return ({1'b0, addr[0:2]} == base_hi) && (addr[3:6] == base) && !addr[7] &&
           ({25'd0, addr[8:14]} < 32'(num_bits));
  endfunction

endpackage

// File: rtl/cru_strobe_sync.sv
// rtl/cru_strobe_sync.sv - CRU strobe synchroniser, falling-edge detect, matched addr/data delay
module cru_strobe_sync
  import cru_pkg::*;
#(
  parameter int         NUM_BITS = 8,
  parameter logic [3:0] BASE_HI  = CRU_SPACE_HI
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cru_clk,
  input  logic [0:14] i_addr,
  input  logic        i_cru_in,
  input  logic [0:3]  i_cru_base,
  output logic        o_wr_stb,
  output logic [6:0]  o_wr_idx,
  output logic        o_wr_hit,
  output logic        o_wr_data
);

  logic        r_s1, r_s2, r_s3;
  logic [0:14] r_a1, r_a2;
  logic        r_d1, r_d2;

  // addr/data ride the same two stages as the strobe so the write sees the values at the fall
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_a1 <= '0;
      r_a2 <= '0;
      r_d1 <= 1'b0;
      r_d2 <= 1'b0;
    end else begin
      r_s1 <= i_cru_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_a1 <= i_addr;
      r_a2 <= r_a1;
      r_d1 <= i_cru_in;
      r_d2 <= r_d1;
    end
  end

  assign o_wr_stb  = r_s3 & ~r_s2;
  assign o_wr_idx  = r_a2[8:14];
  assign o_wr_hit  = cru_hit(r_a2, i_cru_base, BASE_HI, NUM_BITS);
  assign o_wr_data = r_d2;

endmodule

// File: rtl/cru_bit_bank.sv
// rtl/cru_bit_bank.sv - parametrised CRU output-bit bank with pulse bits, readback and change events
module cru_bit_bank
  import cru_pkg::*;
#(
  parameter int                  NUM_BITS   = 8,
  parameter logic [3:0]          BASE_HI    = CRU_SPACE_HI,
  parameter logic [0:NUM_BITS-1] PULSE_MASK = '0,
  parameter int                  PULSE_LEN  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [0:3]          i_cru_base,
  input  logic                i_cru_clk,
  input  logic [0:14]         i_addr,
  input  logic                i_cru_in,
  output logic                o_cru_sel,
  output logic                o_cru_out,
  output logic [0:NUM_BITS-1] o_bits,
  output logic [0:NUM_BITS-1] o_changed
);

  localparam int CNT_W = cru_idx_w(PULSE_LEN + 1);

  if (!cru_params_ok(NUM_BITS, PULSE_LEN)) begin : g_bad_params
    $error("cru_bit_bank: NUM_BITS must be 1..32 and PULSE_LEN >= 1");
  end

  logic                w_wr_stb, w_wr_hit, w_wr_data;
  logic [6:0]          w_wr_idx;
  logic [0:NUM_BITS-1] r_bits, r_changed, w_next;
  logic                r_cru_sel, r_cru_out;
  logic                w_rd_hit, w_rd_bit;

  cru_strobe_sync #(.NUM_BITS(NUM_BITS), .BASE_HI(BASE_HI)) u_sync (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_cru_clk  (i_cru_clk),
    .i_addr     (i_addr),
    .i_cru_in   (i_cru_in),
    .i_cru_base (i_cru_base),
    .o_wr_stb   (w_wr_stb),
    .o_wr_idx   (w_wr_idx),
    .o_wr_hit   (w_wr_hit),
    .o_wr_data  (w_wr_data)
  );

  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
    logic w_wr;
    assign w_wr = w_wr_stb & w_wr_hit & (w_wr_idx == 7'(gi));

    if (PULSE_MASK[gi]) begin : g_pulse
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)          r_cnt <= '0;
        else if (w_wr)           r_cnt <= w_wr_data ? CNT_W'(PULSE_LEN) : '0;
        else if (r_cnt != '0)    r_cnt <= r_cnt - CNT_W'(1);
      end
      // A write on the expiry edge takes priority over the self-clear
      assign w_next[gi] = w_wr ? w_wr_data : ((r_cnt == CNT_W'(1)) ? 1'b0 : r_bits[gi]);
    end else begin : g_latch
      assign w_next[gi] = w_wr ? w_wr_data : r_bits[gi];
    end
  end

  assign w_rd_hit = cru_hit(i_addr, i_cru_base, BASE_HI, NUM_BITS);

  always_comb begin
    w_rd_bit = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (i_addr[8:14] == 7'(i)) w_rd_bit = r_bits[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bits    <= '0;
      r_changed <= '0;
      r_cru_sel <= 1'b0;
      r_cru_out <= 1'b0;
    end else begin
      r_bits    <= w_next;
      r_changed <= w_next ^ r_bits;
      r_cru_sel <= w_rd_hit;
      r_cru_out <= w_rd_hit & w_rd_bit;
    end
  end

  assign o_bits    = r_bits;
  assign o_changed = r_changed;
  assign o_cru_sel = r_cru_sel;
  assign o_cru_out = r_cru_out;

endmodule

// File: tb/tb_cru_bit_bank.sv
// tb/tb_cru_bit_bank.sv - directed self-checking bench for cru_bit_bank
module tb_cru_bit_bank;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [0:3]  cru_base = 4'h2;
  logic        cru_clk = 1'b1;
  logic [0:14] addr = 15'h0000;
  logic        cru_in = 1'b0;
  logic        cru_sel, cru_out;
  logic [0:7]  bits, changed;
  logic [0:7]  pre;

  int n_checks = 0;
  int n_fails  = 0;
  int hi_cnt   = 0;
  int ch_cnt   = 0;

  cru_bit_bank #(
    .NUM_BITS   (8),
    .BASE_HI    (4'h1),
    .PULSE_MASK (8'h80),
    .PULSE_LEN  (16)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_cru_base (cru_base),
    .i_cru_clk  (cru_clk),
    .i_addr     (addr),
    .i_cru_in   (cru_in),
    .o_cru_sel  (cru_sel),
    .o_cru_out  (cru_out),
    .o_bits     (bits),
    .o_changed  (changed)
  );

  always #5 clk = ~clk;

  // Per-cycle tally of the pulse bit and its change events
  always @(posedge clk) begin
    #3;
    if (bits[0])    hi_cnt++;
    if (changed[0]) ch_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with cru_clk high and settled; returns at the negedge after E3
  task automatic strobe(input logic [0:14] a, input logic d, output logic [0:7] pre_bits);
    addr    = a;
    cru_in  = d;
    cru_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    pre_bits = bits;
    @(posedge clk);
    @(negedge clk);
    cru_clk = 1'b1;
  endtask

  task automatic wait_bit0_low(input int budget);
    int k = 0;
    while (bits[0] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("pulse_end_bound", 32'(bits[0]), 32'd0);
  endtask

  logic [0:14] miss_addr [3] = '{15'h1303, 15'h1208, 15'h2203};
  logic        miss_data [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    addr   = 15'h1203;
    cru_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      cru_clk = ~cru_clk;
    end
    @(negedge clk);
    check_val("rst_bits", 32'(bits), 32'h00);
    check_val("rst_changed", 32'(changed), 32'h00);
    check_val("rst_cru_out", 32'(cru_out), 32'd0);
    check_val("rst_cru_sel", 32'(cru_sel), 32'd0);
    reset_n = 1'b1;
    idle(6);
    check_val("rst_no_write", 32'(bits), 32'h00);
    check_val("rst_sel_after", 32'(cru_sel), 32'd1);

    strobe(15'h1203, 1'b1, pre);
    check_val("wr_latency", 32'(pre), 32'h00);
    check_val("wr_bits", 32'(bits), 32'h10);
    check_val("wr_changed", 32'(changed), 32'h10);
    @(negedge clk);
    check_val("chg_one_clk", 32'(changed), 32'h00);
    idle(5);
    strobe(15'h1203, 1'b1, pre);
    check_val("rewrite_bits", 32'(bits), 32'h10);
    check_val("rewrite_no_chg", 32'(changed), 32'h00);
    idle(5);

    for (int i = 0; i < 3; i++) begin
      strobe(miss_addr[i], miss_data[i], pre);
      check_val($sformatf("miss%0d_bits", i), 32'(bits), 32'h10);
      check_val($sformatf("miss%0d_chg", i), 32'(changed), 32'h00);
      check_val($sformatf("miss%0d_sel", i), 32'(cru_sel), 32'd0);
      idle(5);
    end

    strobe(15'h1205, 1'b1, pre);
    check_val("rb_wr_bits", 32'(bits), 32'h14);
    idle(5);
    addr = 15'h1303;
    @(negedge clk);
    check_val("rb_miss_sel", 32'(cru_sel), 32'd0);
    check_val("rb_miss_out", 32'(cru_out), 32'd0);
    addr = 15'h1205;
    @(negedge clk);
    check_val("rb5_sel", 32'(cru_sel), 32'd1);
    check_val("rb5_out", 32'(cru_out), 32'd1);
    addr = 15'h1204;
    @(negedge clk);
    check_val("rb4_sel", 32'(cru_sel), 32'd1);
    check_val("rb4_out", 32'(cru_out), 32'd0);
    addr = 15'h1203;
    @(negedge clk);
    check_val("rb3_out", 32'(cru_out), 32'd1);
    idle(3);

    hi_cnt = 0; ch_cnt = 0;
    strobe(15'h1200, 1'b1, pre);
    check_val("pulse_rise_bits", 32'(bits), 32'h94);
    check_val("pulse_rise_chg", 32'(changed), 32'h80);
    wait_bit0_low(60);
    check_val("pulse_len", 32'(hi_cnt), 32'd16);
    check_val("pulse_chg_cnt", 32'(ch_cnt), 32'd2);
    check_val("pulse_others", 32'(bits), 32'h14);
    idle(5);

    hi_cnt = 0; ch_cnt = 0;
    strobe(15'h1200, 1'b1, pre);
    idle(7);
    strobe(15'h1200, 1'b1, pre);
    check_val("retrig_no_chg", 32'(changed), 32'h00);
    wait_bit0_low(80);
    check_val("retrig_len", 32'(hi_cnt), 32'd26);
    check_val("retrig_chg_cnt", 32'(ch_cnt), 32'd2);
    idle(5);

    hi_cnt = 0; ch_cnt = 0;
    strobe(15'h1200, 1'b1, pre);
    idle(4);
    strobe(15'h1200, 1'b0, pre);
    check_val("wr0_pre", 32'(pre[0]), 32'd1);
    check_val("wr0_bits", 32'(bits), 32'h14);
    check_val("wr0_chg", 32'(changed), 32'h80);
    check_val("wr0_len", 32'(hi_cnt), 32'd7);
    idle(20);
    check_val("wr0_chg_cnt", 32'(ch_cnt), 32'd2);
    check_val("wr0_stays", 32'(bits), 32'h14);
    idle(5);

    strobe(15'h1200, 1'b1, pre);
    idle(4);
    addr    = 15'h1206;
    cru_in  = 1'b1;
    cru_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check_val("midrst_bits", 32'(bits), 32'h00);
    check_val("midrst_chg", 32'(changed), 32'h00);
    check_val("midrst_out", 32'(cru_out), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(6);
    check_val("midrst_no_write", 32'(bits), 32'h00);
    cru_clk = 1'b1;
    idle(6);
    check_val("midrst_rise_quiet", 32'(bits), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
